// File: rtl/training_pkg.sv
// Shared definitions for the training-pattern transmitter.
// Holds the base patterns, the state encoding and the rotation helper.
package training_pkg;

  localparam logic [7:0] PAT_EVEN = 8'h43;
  localparam logic [7:0] PAT_ODD  = 8'h39;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Rotate a byte left by 2*k bits, k in 0..3.
  function automatic logic [7:0] rotl2k(input logic [7:0] word, input logic [1:0] k);
    logic [7:0] res;
    case (k)
      2'd0:    res = word;
      2'd1:    res = {word[5:0], word[7:6]};
      2'd2:    res = {word[3:0], word[7:4]};
      default: res = {word[1:0], word[7:2]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/training_lane.sv
// One byte lane: rotation register plus the registered output word.
// The word is chosen from the state the top level is about to enter.
module training_lane
  import training_pkg::*;
#(
  parameter logic [7:0] BASE = PAT_EVEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     next_state,
  input  logic [7:0] data_in,
  input  logic [1:0] rot,
  input  logic       rot_stb,
  output logic [7:0] lane_out
);

  logic [1:0] rot_q;
  logic [1:0] rot_eff;

  // A strobe on this edge already steers the word registered on this edge.
  assign rot_eff = rot_stb ? rot : rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q    <= 2'd0;
      lane_out <= 8'h00;
    end else begin
      if (rot_stb) begin
        rot_q <= rot;
      end
      case (next_state)
        TRAIN:   lane_out <= rotl2k(BASE, rot_eff);
        DATA:    lane_out <= data_in;
        default: lane_out <= 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/training_pattern_tx.sv
// Multi-lane training-word transmitter with a four-phase train_req/train_ack
// handshake that enforces a minimum training length before payload passthrough.
module training_pattern_tx
  import training_pkg::*;
#(
  parameter int NLANES    = 4,
  parameter int MIN_TRAIN = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  train_req,
  output logic                  train_ack,
  input  logic [8*NLANES-1:0]   data_in,
  input  logic [2*NLANES-1:0]   rot,
  input  logic                  rot_stb,
  output logic [8*NLANES-1:0]   lane_out,
  output logic                  training,
  output logic [15:0]           train_cnt
);

  localparam logic [15:0] MIN_CNT = 16'(MIN_TRAIN);

  state_t      state_q;
  state_t      next_state;
  logic [15:0] cnt_next;
  logic        ack_next;
  logic        training_next;
  logic        cnt_met;

  assign cnt_met = (train_cnt >= MIN_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // An early drop of train_req is remembered simply by staying in TRAIN
  // until the count is met.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (train_req) next_state = TRAIN;
      TRAIN:   if (!train_req && cnt_met) next_state = DATA;
      DATA:    if (train_req) next_state = TRAIN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = train_cnt;
    if (next_state == TRAIN) begin
      if (state_q != TRAIN) begin
        cnt_next = 16'd1;
      end else if (train_cnt != 16'hFFFF) begin
        cnt_next = train_cnt + 16'd1;
      end
    end
    training_next = (next_state == TRAIN);
    ack_next      = (next_state == TRAIN) && train_req && (cnt_next >= MIN_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_cnt <= 16'd0;
      train_ack <= 1'b0;
      training  <= 1'b0;
    end else begin
      train_cnt <= cnt_next;
      train_ack <= ack_next;
      training  <= training_next;
    end
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    training_lane #(
      .BASE((i % 2 == 1) ? PAT_ODD : PAT_EVEN)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .next_state (next_state),
      .data_in    (data_in[8*i +: 8]),
      .rot        (rot[2*i +: 2]),
      .rot_stb    (rot_stb),
      .lane_out   (lane_out[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_training_pattern_tx.sv
// Self-checking bench for training_pattern_tx: behavioural model compared every
// cycle, plus directed literal checks and a saturation run on a second instance.
module tb_training_pattern_tx;

  localparam int NL      = 4;
  localparam int MIN     = 16;
  localparam int MIN_BIG = 65535;

  logic        clk;
  logic        rst_n;
  logic        train_req;
  logic        train_ack;
  logic [31:0] data_in;
  logic [7:0]  rot;
  logic        rot_stb;
  logic [31:0] lane_out;
  logic        training;
  logic [15:0] train_cnt;

  logic        big_req;
  logic        big_stb;
  logic        big_ack;
  logic [31:0] big_lane;
  logic        big_training;
  logic [15:0] big_cnt;

  int compared   = 0;
  int mismatched = 0;

  training_pattern_tx #(.NLANES(NL), .MIN_TRAIN(MIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .train_req (train_req),
    .train_ack (train_ack),
    .data_in   (data_in),
    .rot       (rot),
    .rot_stb   (rot_stb),
    .lane_out  (lane_out),
    .training  (training),
    .train_cnt (train_cnt)
  );

  training_pattern_tx #(.NLANES(NL), .MIN_TRAIN(MIN_BIG)) dut_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .train_req (big_req),
    .train_ack (big_ack),
    .data_in   (data_in),
    .rot       (rot),
    .rot_stb   (big_stb),
    .lane_out  (big_lane),
    .training  (big_training),
    .train_cnt (big_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Training words straight from the published rotation tables.
  logic [7:0] even_tab [4] = '{8'h43, 8'h0d, 8'h34, 8'hd0};
  logic [7:0] odd_tab  [4] = '{8'h39, 8'he4, 8'h93, 8'h4e};

  typedef struct {
    int          phase;   // 0 idle, 1 training, 2 passthrough
    int          cnt;
    logic [7:0]  rotv;
    logic [31:0] lane;
    bit          ack;
    bit          trn;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic req, input logic stb,
                                         input logic [7:0] rot_in, input logic [31:0] din);
    mstate_t n;
    n      = s;
    n.rotv = stb ? rot_in : s.rotv;
    if (s.phase != 1) begin
      if (req) begin
        n.phase = 1;
        n.cnt   = 1;
      end
    end else if (!req && s.cnt >= MIN) begin
      n.phase = 2;
    end else begin
      n.cnt = (s.cnt + 1 > 65535) ? 65535 : s.cnt + 1;
    end
    for (int i = 0; i < NL; i++) begin
      if (n.phase == 1)
        n.lane[8*i +: 8] = (i % 2 == 1) ? odd_tab[n.rotv[2*i +: 2]] : even_tab[n.rotv[2*i +: 2]];
      else if (n.phase == 2)
        n.lane[8*i +: 8] = din[8*i +: 8];
      else
        n.lane[8*i +: 8] = 8'h00;
    end
    n.trn = (n.phase == 1);
    n.ack = (n.phase == 1) && req && (n.cnt >= MIN);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m <= '{0, 0, 8'h00, 32'h0, 1'b0, 1'b0};
    else
      m <= model_step(m, train_req, rot_stb, rot, data_in);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("model_lane_out", lane_out, m.lane);
    checkOutput("model_train_cnt", {16'h0, train_cnt}, 32'(m.cnt));
    checkOutput("model_training", {31'h0, training}, {31'h0, m.trn});
    checkOutput("model_train_ack", {31'h0, train_ack}, {31'h0, m.ack});
  end

  task automatic applyStimulus(input logic req, input logic stb, input logic [7:0] r,
                               input logic [31:0] din);
    train_req = req;
    rot_stb   = stb;
    rot       = r;
    data_in   = din;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    train_req = 1'b0;
    rot_stb   = 1'b0;
    rot       = 8'h00;
    data_in   = 32'h0;
    big_req   = 1'b0;
    big_stb   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_lane_out", lane_out, 32'h0);
    checkOutput("reset_train_cnt", {16'h0, train_cnt}, 32'h0);
    checkOutput("reset_training", {31'h0, training}, 32'h0);
    checkOutput("reset_train_ack", {31'h0, train_ack}, 32'h0);
    rst_n = 1'b1;

    // First session: patterns from the first edge, ack after MIN words.
    applyStimulus(1'b1, 1'b0, 8'h00, 32'hAAAA5555);
    checkOutput("first_word", lane_out, 32'h39433943);
    checkOutput("first_cnt", {16'h0, train_cnt}, 32'd1);
    checkOutput("first_training", {31'h0, training}, 32'd1);
    repeat (14) applyStimulus(1'b1, 1'b0, 8'h00, 32'hAAAA5555);
    checkOutput("cnt15", {16'h0, train_cnt}, 32'd15);
    checkOutput("ack_before_min", {31'h0, train_ack}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'hAAAA5555);
    checkOutput("cnt16", {16'h0, train_cnt}, 32'd16);
    checkOutput("ack_at_min", {31'h0, train_ack}, 32'd1);

    // Rotation strobe during training.
    applyStimulus(1'b1, 1'b1, 8'hE4, 32'hAAAA5555);
    checkOutput("rot_word", lane_out, 32'h4e34e443);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'hAAAA5555);
    checkOutput("rot_latched", lane_out, 32'h4e34e443);
    checkOutput("cnt18", {16'h0, train_cnt}, 32'd18);

    // Release with count satisfied: passthrough with one-cycle latency.
    applyStimulus(1'b0, 1'b0, 8'h00, 32'hDEADBEEF);
    checkOutput("data_first", lane_out, 32'hDEADBEEF);
    checkOutput("data_training", {31'h0, training}, 32'd0);
    checkOutput("data_ack", {31'h0, train_ack}, 32'd0);
    checkOutput("data_cnt_hold", {16'h0, train_cnt}, 32'd18);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h12345678);
    checkOutput("data_second", lane_out, 32'h12345678);

    // Re-entry from passthrough keeps rotation; early drop at 10 words.
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);
    checkOutput("reentry_cnt", {16'h0, train_cnt}, 32'd1);
    checkOutput("reentry_word", lane_out, 32'h4e34e443);
    repeat (9) applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);
    checkOutput("cnt10", {16'h0, train_cnt}, 32'd10);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'h00, 32'hCAFEF00D);
    checkOutput("early_drop_cnt16", {16'h0, train_cnt}, 32'd16);
    checkOutput("early_drop_training", {31'h0, training}, 32'd1);
    checkOutput("early_drop_no_ack", {31'h0, train_ack}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0BADC0DE);
    checkOutput("early_drop_data", lane_out, 32'h0BADC0DE);
    checkOutput("early_drop_exit", {31'h0, training}, 32'd0);

    // Strobe coinciding with the transition into training.
    applyStimulus(1'b1, 1'b1, 8'h1B, 32'h0);
    checkOutput("stb_with_entry", lane_out, 32'h390d93d0);
    checkOutput("stb_with_entry_cnt", {16'h0, train_cnt}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_lane_out", lane_out, 32'h0);
    checkOutput("async_training", {31'h0, training}, 32'd0);
    checkOutput("async_cnt", {16'h0, train_cnt}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    train_req = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'hFF, 32'h77777777);
    checkOutput("post_reset_idle", lane_out, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    checkOutput("post_reset_rot_cleared", lane_out, 32'h39433943);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);

    // Saturation on the large-minimum instance.
    big_req = 1'b1;
    repeat (65534) @(negedge clk);
    checkOutput("big_cnt_65534", {16'h0, big_cnt}, 32'd65534);
    checkOutput("big_ack_65534", {31'h0, big_ack}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("big_cnt_sat", {16'h0, big_cnt}, 32'h0000FFFF);
      checkOutput("big_ack_sat", {31'h0, big_ack}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/training_pattern_tx.md
# training_pattern_tx

Multi-lane training-word transmitter: the far-end source of the byte patterns that the idelay scanner's decider accepts as valid. Even lanes carry base word 0x43 and odd lanes carry 0x39, each optionally rotated by 2·k bits. A four-phase request/acknowledge handshake guarantees a minimum training length before the block switches the lanes to payload passthrough. It sits in the transmit-side serializer path, upstream of the OSERDES.

## Interface
- NLANES, 4, number of byte lanes; lane i uses the odd pattern set when i is odd
- MIN_TRAIN, 1024, minimum training words emitted before handshake completion; 1..65535
- clk  in  1  single clock; all logic in this domain
- rst_n  in  1  asynchronous, active-low reset
- train_req  in  1  request training; four-phase handshake with train_ack
- train_ack  out  1  minimum training length satisfied while train_req high
- data_in  in  8*NLANES  payload; lane i is data_in[8i+7:8i]
- rot  in  2*NLANES  per-lane rotation index k; lane i is rot[2i+1:2i]
- rot_stb  in  1  latch rot into the per-lane rotation registers
- lane_out  out  8*NLANES  registered lane words to serializer
- training  out  1  high while state is TRAIN
- train_cnt  out  16  training words emitted in current session; saturates at 0xFFFF

## Operation
- States: IDLE, TRAIN, DATA.
  - IDLE: lane_out = 0. train_req high → TRAIN.
  - TRAIN: every cycle each lane emits its training word. train_cnt increments and saturates.
  - TRAIN exit: when train_req is low and train_cnt ≥ MIN_TRAIN → DATA.
  - TRAIN with train_req dropped early (train_cnt < MIN_TRAIN): stay in TRAIN until the count is reached, then → DATA.
  - DATA: lane_out = data_in. train_req high → TRAIN with train_cnt cleared.
- Training word for lane i: base = 0x43 for even i, 0x39 for odd i; rotate left by 2·rot_i bits.
  - Even set: k=0..3 gives 0x43, 0x0d, 0x34, 0xd0.
  - Odd set: k=0..3 gives 0x39, 0xe4, 0x93, 0x4e.
- rot_stb: captures all rot fields in any state. The new rotation affects the word emitted on the next edge.
- train_ack = (state == TRAIN) & train_req & (train_cnt ≥ MIN_TRAIN), registered.
- Simultaneous rot_stb and a state transition: both take effect; the first word of a new TRAIN session already uses the new rotation.
- Reset (any time, asynchronous): state IDLE, lane_out 0, train_ack 0, training 0, train_cnt 0, rotation registers 0. No partial word on release.

## Timing
- Inputs are sampled on the rising edge of clk. All outputs are registered.
- train_req sampled high in IDLE or DATA at edge n:
  - first training word and training=1 appear after edge n.
  - train_cnt = 1 after edge n.
- train_ack rises on the edge where train_cnt becomes ≥ MIN_TRAIN, provided train_req is high.
- train_req sampled low at edge m with the count satisfied: train_ack=0, training=0, and lane_out = data_in (sampled at m) after edge m.
- DATA passthrough latency: 1 cycle.
- train_cnt holds its value in DATA and clears only on entry to TRAIN.

## Structure
- Shared package `training_pkg`:
  - PAT_EVEN = 8'h43, PAT_ODD = 8'h39
  - state encoding IDLE/TRAIN/DATA
  - rotate-by-2k function
- Sub-module `training_lane`, one instance per lane via generate:
  - holds the 2-bit rotation register and the output byte register
  - selects 0, training word, or payload from the top-level state
- Top level holds the state machine, the counter and the handshake.

## Test plan
- Reset, NLANES=4, rot=0, train_req=1:
  - lane_out = 0x39_43_39_43 from the first post-request edge.
  - train_ack rises exactly MIN_TRAIN words after the first training word.
- rot_stb with rot = {2'd3,2'd2,2'd1,2'd0} during TRAIN → next word = 0x4e_34_e4_43.
- train_req dropped after 10 words with MIN_TRAIN=16:
  - training stays high until 16 words are emitted.
  - DATA passthrough follows with 1-cycle latency; train_ack never asserts.
- In DATA, re-assert train_req → train_cnt restarts at 1, training words resume on the next edge, rotation preserved.
- rst_n pulsed low mid-TRAIN (asynchronous, between edges):
  - outputs clear immediately.
  - after release, state is IDLE with rot = 0; lane_out stays 0 until train_req.
- MIN_TRAIN=65535 with train_req held → train_cnt saturates at 0xFFFF without wrap; train_ack stays high.
